mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS variant of the core. It sequences the shared PC/IR/ALU/memory datapath through fetch, decode, execute, memory and writeback, and selects the ALU B operand, including the 16-to-32 sign-extended immediate and its <<2 form. It adds a memory ready handshake with a wait-timeout and an exception pulse for illegal opcodes and timeouts.

Parameters:
WAIT_LIMIT, 15, maximum consecutive cycles with mem_ready=0 in any memory state before a timeout; legal range 1..255.
WAIT_W, 8, width of the wait counter; must satisfy 2**WAIT_W > WAIT_LIMIT.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag, used in BRANCH
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero=1
iord  out  1  0 = memory address from PC, 1 = from ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  writeback source is MDR
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = opcode-defined immediate op
ext_zero  out  1  immediate extender zero-extends instead of sign-extending
pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
exc  out  1  one-cycle exception pulse
exc_code  out  2  01 = illegal opcode, 10 = memory timeout; valid when exc=1
state_dbg  out  4  current state encoding

Behaviour:
- Reset: asynchronous entry to RESET. All outputs 0, state_dbg = 0, wait counter = 0. On the first clock edge after rst_n deasserts: RESET -> FETCH. Reset mid-access drops mem_read/mem_write immediately.
- Outputs are Moore, decoded from state, except ir_write/pc_write in FETCH, which are qualified by mem_ready. Unlisted outputs are 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write = pc_write = mem_ready. mem_ready=1 -> DECODE, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000, 001100, 001101 -> EXEC_I
  - 000010 -> JUMP
  - any other opcode -> TRAP with exc_code 01
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. On mem_ready -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_write=1, iord=1. On mem_ready -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op = 00 for addi, 11 otherwise; ext_zero=1 for andi/ori -> ITYPE_WB.
- ITYPE_WB: reg_write=1, reg_dst=0, with ext_zero and alu_op held from EXEC_I -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- TRAP: exc=1, exc_code as latched on entry -> FETCH after one cycle. PC was already incremented in FETCH, so execution resumes at the next instruction.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and on any cycle with mem_ready=1.
  - Increments on each cycle in those states with mem_ready=0.
  - When it equals WAIT_LIMIT with mem_ready still 0: -> TRAP with exc_code 10; the access is abandoned with no ir_write, pc_write or reg_write.
  - If mem_ready=1 on the limit cycle, the completion wins and no timeout occurs.
- Encoding: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, RTYPE_WB=8, EXEC_I=9, ITYPE_WB=10, BRANCH=11, JUMP=12, TRAP=13. Codes 14 and 15 are unreachable; if entered, go to FETCH.

Decomposition:
- Package mips_ctrl_pkg: opcode constants, state encodings, alu_src_b/alu_op/pc_source/exc_code encodings.
- One sub-module, mips_mem_wait_timer (clear, inc, hit outputs, parameterised by WAIT_LIMIT), instantiated once.

Test Plan:
- Reset, then lw (opcode 100011) with mem_ready held at 1 -> states 1,2,3,4,5,1; one ir_write pulse; alu_src_b=10 in MEMADR; reg_write with mem_to_reg=1 in MEMWB; 5 cycles per instruction.
- beq (000100) with zero=1, then again with zero=0 -> pc_write_cond=1, pc_source=01, alu_op=01 in BRANCH both times; alu_src_b=11 in DECODE; 3 cycles each.
- ori (001101) -> ext_zero=1 and alu_op=11 in EXEC_I/ITYPE_WB; addi (001000) -> ext_zero=0, alu_op=00.
- FETCH with mem_ready low for 3 cycles, then high -> stays in FETCH; ir_write only in the 4th cycle; no exc.
- sw with mem_ready held at 0, WAIT_LIMIT=15 -> after 15 wait cycles enter TRAP; exc=1 for one cycle with exc_code=10; next state FETCH; mem_write drops in TRAP.
- Opcode 111111 -> DECODE to TRAP, exc_code=01; rst_n asserted mid-MEMRD -> all outputs 0 immediately, state_dbg=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states and datapath select codes.
// Pure definitions; no timing or flow-control behaviour of its own.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXEC_R   = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_EXEC_I   = 4'd9,
        S_ITYPE_WB = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    // States that issue a memory access and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive memory wait cycles; hit is combinational from the count register.
// No flow control: clear has priority over inc, and the count holds once the limit is reached.
module mips_mem_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic hit
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_LIMIT[WAIT_W-1:0];
    localparam logic [WAIT_W-1:0] ONE   = 1;

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !hit) begin
            cnt <= cnt + ONE;
        end
    end

    assign hit = (cnt == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with mem_ready wait, timeout and illegal-opcode trap.
// Moore outputs (FETCH ir_write/pc_write gated by mem_ready); stalls in memory states until mem_ready or timeout.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_zero,
    output logic [1:0] pc_source,
    output logic       exc,
    output logic [1:0] exc_code,
    output logic [3:0] state_dbg
);

    state_t     state_q, state_d;
    logic [1:0] exc_code_q, exc_code_d;
    logic       in_mem;
    logic       wait_hit;
    logic       timeout;
    logic       imm_zext;
    logic [1:0] imm_alu_op;

    assign in_mem  = is_mem_state(state_q);
    assign timeout = in_mem && !mem_ready && wait_hit;

    // Counter stays at zero outside memory states, so entry always starts from a clean count.
    mips_mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .WAIT_W     (WAIT_W)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!in_mem || mem_ready),
        .inc   (in_mem && !mem_ready),
        .hit   (wait_hit)
    );

    // The IR is stable through EXEC_I and ITYPE_WB, so both states decode the same immediate op.
    assign imm_zext   = (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign imm_alu_op = (opcode == OP_ADDI) ? ALU_ADD : ALU_IMM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            exc_code_q <= EXC_NONE;
        end else begin
            state_q    <= state_d;
            exc_code_q <= exc_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exc_code_d = exc_code_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (timeout) begin
                    state_d    = S_TRAP;
                    exc_code_d = EXC_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                  state_d = S_EXEC_R;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
                    OP_J:                      state_d = S_JUMP;
                    default: begin
                        state_d    = S_TRAP;
                        exc_code_d = EXC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (timeout) begin
                    state_d    = S_TRAP;
                    exc_code_d = EXC_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (timeout) begin
                    state_d    = S_TRAP;
                    exc_code_d = EXC_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R:   state_d = S_RTYPE_WB;
            S_EXEC_I:   state_d = S_ITYPE_WB;
            S_MEMWB, S_RTYPE_WB, S_ITYPE_WB, S_BRANCH, S_JUMP, S_TRAP:
                        state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        ext_zero      = 1'b0;
        pc_source     = PCSRC_ALU;
        exc           = 1'b0;
        exc_code      = EXC_NONE;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = imm_alu_op;
                ext_zero  = imm_zext;
            end
            S_ITYPE_WB: begin
                reg_write = 1'b1;
                alu_op    = imm_alu_op;
                ext_zero  = imm_zext;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_TRAP: begin
                exc      = 1'b1;
                exc_code = exc_code_q;
            end
            default: ;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instruction sequences, memory waits, timeout, trap and reset.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, exc;
    logic [1:0] alu_src_b, alu_op, pc_source, exc_code;
    logic [3:0] state_dbg;

    int checks = 0;
    int failures = 0;

    mips_multicycle_ctrl #(.WAIT_LIMIT(15), .WAIT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .ext_zero      (ext_zero),
        .pc_source     (pc_source),
        .exc           (exc),
        .exc_code      (exc_code),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        #3;
        chk_s("rst_state", state_dbg, 4'd0);
        chk_b("rst_mem_read", mem_read, 1'b0);
        chk_b("rst_pc_write", pc_write, 1'b0);
        chk_b("rst_ir_write", ir_write, 1'b0);
        chk_b("rst_exc", exc, 1'b0);
        chk2("rst_srcb", alu_src_b, 2'b00);
        #8 rst_n = 1'b1;
        tick();
        chk_s("post_rst_fetch", state_dbg, 4'd1);

        // lw, memory always ready
        opcode = 6'b100011; mem_ready = 1'b1; #1;
        chk_b("lw_fetch_mem_read", mem_read, 1'b1);
        chk_b("lw_fetch_ir_write", ir_write, 1'b1);
        chk_b("lw_fetch_pc_write", pc_write, 1'b1);
        chk2("lw_fetch_srcb", alu_src_b, 2'b01);
        tick();
        chk_s("lw_decode", state_dbg, 4'd2);
        chk_b("lw_decode_ir_write", ir_write, 1'b0);
        chk2("lw_decode_srcb", alu_src_b, 2'b11);
        tick();
        chk_s("lw_memadr", state_dbg, 4'd3);
        chk2("lw_memadr_srcb", alu_src_b, 2'b10);
        chk_b("lw_memadr_srca", alu_src_a, 1'b1);
        tick();
        chk_s("lw_memrd", state_dbg, 4'd4);
        chk_b("lw_memrd_read", mem_read, 1'b1);
        chk_b("lw_memrd_iord", iord, 1'b1);
        chk_b("lw_memrd_ir_write", ir_write, 1'b0);
        tick();
        chk_s("lw_memwb", state_dbg, 4'd5);
        chk_b("lw_memwb_reg_write", reg_write, 1'b1);
        chk_b("lw_memwb_mem_to_reg", mem_to_reg, 1'b1);
        chk_b("lw_memwb_reg_dst", reg_dst, 1'b0);
        tick();
        chk_s("lw_back_fetch", state_dbg, 4'd1);

        // R-type
        opcode = 6'b000000; #1;
        tick();
        tick();
        chk_s("r_exec", state_dbg, 4'd7);
        chk2("r_exec_alu_op", alu_op, 2'b10);
        chk2("r_exec_srcb", alu_src_b, 2'b00);
        tick();
        chk_s("r_wb", state_dbg, 4'd8);
        chk_b("r_wb_reg_dst", reg_dst, 1'b1);
        chk_b("r_wb_reg_write", reg_write, 1'b1);
        tick();
        chk_s("r_back_fetch", state_dbg, 4'd1);

        // beq taken and not taken: controls are identical, zero is consumed by the datapath
        for (int b = 0; b < 2; b++) begin
            opcode = 6'b000100; zero = (b == 0); #1;
            tick();
            chk2("beq_decode_srcb", alu_src_b, 2'b11);
            chk2("beq_decode_alu_op", alu_op, 2'b00);
            tick();
            chk_s("beq_branch", state_dbg, 4'd11);
            chk_b("beq_pc_write_cond", pc_write_cond, 1'b1);
            chk2("beq_pc_source", pc_source, 2'b01);
            chk2("beq_alu_op", alu_op, 2'b01);
            chk_b("beq_pc_write", pc_write, 1'b0);
            tick();
            chk_s("beq_back_fetch", state_dbg, 4'd1);
        end

        // ori then addi
        opcode = 6'b001101; #1;
        tick();
        tick();
        chk_s("ori_exec", state_dbg, 4'd9);
        chk_b("ori_exec_ext_zero", ext_zero, 1'b1);
        chk2("ori_exec_alu_op", alu_op, 2'b11);
        chk2("ori_exec_srcb", alu_src_b, 2'b10);
        tick();
        chk_s("ori_wb", state_dbg, 4'd10);
        chk_b("ori_wb_ext_zero", ext_zero, 1'b1);
        chk2("ori_wb_alu_op", alu_op, 2'b11);
        chk_b("ori_wb_reg_write", reg_write, 1'b1);
        tick();
        opcode = 6'b001000; #1;
        tick();
        tick();
        chk_s("addi_exec", state_dbg, 4'd9);
        chk_b("addi_exec_ext_zero", ext_zero, 1'b0);
        chk2("addi_exec_alu_op", alu_op, 2'b00);
        tick();
        chk_b("addi_wb_ext_zero", ext_zero, 1'b0);
        chk2("addi_wb_alu_op", alu_op, 2'b00);
        tick();

        // jump
        opcode = 6'b000010; #1;
        tick();
        tick();
        chk_s("j_state", state_dbg, 4'd12);
        chk_b("j_pc_write", pc_write, 1'b1);
        chk2("j_pc_source", pc_source, 2'b10);
        tick();
        chk_s("j_back_fetch", state_dbg, 4'd1);

        // FETCH stalled three cycles, then sw whose write never completes
        opcode = 6'b101011; mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk_s("fwait_state", state_dbg, 4'd1);
            chk_b("fwait_ir_write", ir_write, 1'b0);
            chk_b("fwait_pc_write", pc_write, 1'b0);
            chk_b("fwait_exc", exc, 1'b0);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk_s("fwait_done_state", state_dbg, 4'd1);
        chk_b("fwait_done_ir_write", ir_write, 1'b1);
        chk_b("fwait_done_exc", exc, 1'b0);
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk_s("sw_memwr", state_dbg, 4'd6);
        chk_b("sw_mem_write", mem_write, 1'b1);
        chk_b("sw_iord", iord, 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk_s("sw_wait_state", state_dbg, 4'd6);
        end
        tick();
        chk_s("sw_timeout_trap", state_dbg, 4'd13);
        chk_b("sw_timeout_exc", exc, 1'b1);
        chk2("sw_timeout_code", exc_code, 2'b10);
        chk_b("sw_trap_mem_write", mem_write, 1'b0);
        chk_b("sw_trap_reg_write", reg_write, 1'b0);
        tick();
        chk_s("sw_trap_to_fetch", state_dbg, 4'd1);
        chk_b("sw_exc_pulse_end", exc, 1'b0);

        // illegal opcode
        opcode = 6'b111111; mem_ready = 1'b1; #1;
        tick();
        chk_b("ill_decode_exc", exc, 1'b0);
        tick();
        chk_s("ill_trap", state_dbg, 4'd13);
        chk_b("ill_exc", exc, 1'b1);
        chk2("ill_code", exc_code, 2'b01);
        tick();
        chk_s("ill_back_fetch", state_dbg, 4'd1);

        // lw whose read completes exactly on the limit cycle
        opcode = 6'b100011; #1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk_s("lim_memrd", state_dbg, 4'd4);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk_s("lim_wait_state", state_dbg, 4'd4);
        end
        mem_ready = 1'b1; #1;
        chk_b("lim_no_exc", exc, 1'b0);
        tick();
        chk_s("lim_memwb", state_dbg, 4'd5);
        tick();

        // reset asserted in the middle of a read
        opcode = 6'b100011; mem_ready = 1'b1; #1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk_b("mid_rst_pre_read", mem_read, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_s("mid_rst_state", state_dbg, 4'd0);
        chk_b("mid_rst_mem_read", mem_read, 1'b0);
        chk_b("mid_rst_iord", iord, 1'b0);
        chk_b("mid_rst_mem_write", mem_write, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk_s("mid_rst_fetch", state_dbg, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
